spi_slave_regbank: RTL and testbench
====================================

Name: spi_slave_regbank

Overview:
- Parametrised SPI slave (mode 0: CPOL=0, CPHA=0) bridging the Raspberry Pi and FPGA register space.
- Generalises the fixed 40-bit single-transfer slave with configurable word width, address width and bank depths.
- Adds multi-word burst transfers with address auto-increment, atomic read snapshot at frame start, per-register write strobes and a frame-error counter.
- Sits between the SPI pins and the application logic (odometry, colour sensor, motor control).

Parameters:
DATA_W, 32, register word width in bits (>=8)
ADDR_W, 4, register address width (1..7)
N_WR, 16, number of Pi-writable registers (<=2**ADDR_W)
N_RD, 16, number of Pi-readable registers (<=2**ADDR_W)
SYNC_STAGES, 2, flip-flop stages on SPI_CLK/SPI_CS/SPI_MOSI (>=2)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
SPI_CLK  in  1  SPI serial clock (async); max frequency clk/8
SPI_CS  in  1  chip select, active low (async)
SPI_MOSI  in  1  master-out data (async)
SPI_MISO  out  1  slave-out data, registered
miso_data  in  N_RD*DATA_W  read registers; word i = [i*DATA_W +: DATA_W]
mosi_data  out  N_WR*DATA_W  write registers, same packing
wr_strobe  out  N_WR  one-clk pulse per written register
frame_err_cnt  out  8  saturating count of malformed frames

Behaviour:
- Reset: SPI_MISO=0, mosi_data=0, wr_strobe=0, frame_err_cnt=0, FSM=IDLE, snapshot=0, bit counter=0.
- Reset mid-frame: same values; FSM goes to WAIT_CS_HIGH and ignores traffic until SPI_CS is seen high, then waits for a fresh falling edge.
- Sync: each SPI input passes through SYNC_STAGES flops. Edges are detected by comparing the last stage with one extra delayed copy. All edge events are single-clk pulses.
- Frame format (MSB first):
  - Byte 0 = {W, pad, addr[ADDR_W-1:0]}. W=1 means write, W=0 means read. Pad bits are ignored.
  - Byte 0 is followed by any number of DATA_W-bit words.
- MOSI sampling: on every SPI_CLK rising edge. MISO is updated on SPI_CLK falling edges and on load.
- FSM states:
  - IDLE: on CS falling edge, copy all miso_data into snapshot (atomic), clear counters, SPI_MISO=0, go to CMD.
  - CMD: shift 8 bits. After the 8th rising edge, latch W and addr; go to DATA. SPI_MISO stays 0 during the command byte.
  - DATA: on each falling edge, shift out the next shift-register bit.
    - Read: on the falling edge after the last bit of the command byte or of a word, load snapshot[addr], drive its MSB immediately, then increment addr. Address >= N_RD loads 0.
    - Write: after the DATA_W-th rising edge of a word, write the word to mosi_data[addr] in the next clk, pulse wr_strobe[addr] in that same clk, then increment addr. Address >= N_WR: no write, no strobe.
    - Addr wraps modulo 2**ADDR_W.
  - WAIT_CS_HIGH: on CS high, go to IDLE.
- CS rising edge in CMD or DATA:
  - If the bit count within the current word/byte is nonzero, or the frame ended in CMD, increment frame_err_cnt (saturates at 255) and discard the partial word.
  - In all cases go to IDLE and set SPI_MISO=0.
- CS high forces IDLE regardless of state, with priority over any SPI_CLK edge in the same clk.
- Simultaneous write-complete and CS rising in the same clk: the completed word is committed and the strobe issues; no error.
- Read frames never modify mosi_data. wr_strobe is never asserted outside write frames.

Test Plan:
- Reset then idle: all outputs 0; an SPI_CLK toggle with CS high -> no strobe, MISO=0.
- Single write, defaults: cmd 0x83, data 0xDEADBEEF -> mosi_data word 3 = 0xDEADBEEF; wr_strobe=0x0008 for exactly 1 clk; other words unchanged.
- Burst read with snapshot: miso_data word 14 = 0x11112222, word 15 = 0x33334444, word 0 = 0x55556666. Cmd 0x0E, read 3 words; change miso_data after CS falls. Expected MISO stream: 0x11112222, 0x33334444, 0x55556666 (pre-change values, addr wraps 15->0).
- N_WR=8 boundary burst: cmd 0x87 plus 2 words (0xA, 0xB) -> word 7 = 0xA, strobe bit 7 only; address 8 is ignored with no strobe.
- Malformed frame: CS raised after cmd 0x81 plus 20 data bits -> no write, frame_err_cnt=1. Repeat 300 times -> frame_err_cnt=255.
- Reset at bit 12 of a write word: mosi_data=0. Remaining bits and CS rise cause no write and no error increment. The next full frame (cmd 0x82, 0x12345678) writes correctly.

Source files
------------

// File: rtl/spi_slave_regbank.sv
// Mode-0 SPI slave bridging a host to banks of write and read registers.
// Supports burst transfers with address auto-increment and a frame-start read snapshot.
//
// state        | meaning
// IDLE         | waiting for a chip-select falling edge
// CMD          | shifting in the command byte {W, pad, addr}
// DATA         | streaming words; reads load the snapshot, writes commit per word
// WAIT_CS_HIGH | reset landed mid-frame; ignore traffic until CS deasserts
module spi_slave_regbank #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 4,
   parameter int N_WR        = 16,
   parameter int N_RD        = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   SPI_CLK,
   input  logic                   SPI_CS,
   input  logic                   SPI_MOSI,
   output logic                   SPI_MISO,
   input  logic [N_RD*DATA_W-1:0] miso_data,
   output logic [N_WR*DATA_W-1:0] mosi_data,
   output logic [N_WR-1:0]        wr_strobe,
   output logic [7:0]             frame_err_cnt
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS_HIGH} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_rise, sclk_fall, cs_fall;

   logic [CNT_W-1:0]       bit_cnt;
   logic [DATA_W-1:0]      rx_sh, tx_sh, rx_word, rd_word, wr_word;
   logic [N_RD*DATA_W-1:0] snapshot;
   logic [ADDR_W-1:0]      addr, wr_addr;
   logic                   is_wr, wr_pend;
   logic                   word_end, word_done, frame_err;

   // synchronisers are left unreset so the CS level is valid while reset is held
   always_ff @(posedge clk) begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;

   assign rx_word   = {rx_sh[DATA_W-2:0], mosi_s};
   assign word_end  = (state == DATA) && sclk_rise && (bit_cnt == WORD_LAST);
   assign word_done = word_end && is_wr;
   // a word completing in the same clk that CS rises is not a partial word
   assign frame_err = cs_s && ((state == CMD) ||
                               ((state == DATA) && (bit_cnt != '0) && !word_end));

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < N_RD; i++)
         if (int'(addr) == i) rd_word = snapshot[i*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= cs_s ? IDLE : WAIT_CS_HIGH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:         if (cs_fall) state_nxt = CMD;
         CMD: begin
            if (cs_s)                                 state_nxt = IDLE;
            else if (sclk_rise && bit_cnt == CMD_LAST) state_nxt = DATA;
         end
         DATA:         if (cs_s) state_nxt = IDLE;
         WAIT_CS_HIGH: if (cs_s) state_nxt = IDLE;
         default:      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         SPI_MISO      <= 1'b0;
         mosi_data     <= '0;
         wr_strobe     <= '0;
         frame_err_cnt <= '0;
         snapshot      <= '0;
         bit_cnt       <= '0;
         rx_sh         <= '0;
         tx_sh         <= '0;
         wr_word       <= '0;
         addr          <= '0;
         wr_addr       <= '0;
         is_wr         <= 1'b0;
         wr_pend       <= 1'b0;
      end else begin
         wr_strobe <= '0;
         wr_pend   <= 1'b0;
         if (wr_pend) begin
            for (int i = 0; i < N_WR; i++)
               if (int'(wr_addr) == i) begin
                  mosi_data[i*DATA_W +: DATA_W] <= wr_word;
                  wr_strobe[i]                  <= 1'b1;
               end
         end
         if (word_done) begin
            wr_pend <= 1'b1;
            wr_word <= rx_word;
            wr_addr <= addr;
         end
         if (frame_err && frame_err_cnt != 8'hFF)
            frame_err_cnt <= frame_err_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  snapshot <= miso_data;
                  bit_cnt  <= '0;
                  tx_sh    <= '0;
                  SPI_MISO <= 1'b0;
               end
            end
            CMD, DATA: begin
               if (cs_s) begin
                  SPI_MISO <= 1'b0;
                  bit_cnt  <= '0;
               end else if (sclk_rise) begin
                  rx_sh <= rx_word;
                  if (state == CMD && bit_cnt == CMD_LAST) begin
                     bit_cnt <= '0;
                     is_wr   <= rx_word[7];
                     addr    <= ADDR_W'(rx_word[7:0]);
                  end else if (state == DATA && bit_cnt == WORD_LAST) begin
                     bit_cnt <= '0;
                     if (is_wr) addr <= addr + ADDR_W'(1);
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (sclk_fall && state == DATA) begin
                  if (!is_wr && bit_cnt == '0) begin
                     SPI_MISO <= rd_word[DATA_W-1];
                     tx_sh    <= rd_word << 1;
                     addr     <= addr + ADDR_W'(1);
                  end else begin
                     SPI_MISO <= tx_sh[DATA_W-1];
                     tx_sh    <= tx_sh << 1;
                  end
               end
            end
            default: begin
               SPI_MISO <= 1'b0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench for spi_slave_regbank: a default-sized instance plus one with
// an eight-register write bank, both sharing the same SPI bus and reset.
module tb_spi_slave_regbank;
   localparam int HALF = 60;

   logic             clk = 1'b0;
   logic             reset, SPI_CLK, SPI_CS, SPI_MOSI;
   logic             SPI_MISO, SPI_MISO8;
   logic [16*32-1:0] miso_data;
   logic [16*32-1:0] mosi_data;
   logic [8*32-1:0]  mosi_data8;
   logic [15:0]      wr_strobe;
   logic [7:0]       wr_strobe8;
   logic [7:0]       frame_err_cnt, frame_err_cnt8;

   logic [16*32-1:0] exp0;
   logic [8*32-1:0]  exp8;
   logic [15:0]      sq0[$];
   logic [7:0]       sq8[$];
   int               n_checks = 0;
   int               n_pass   = 0;

   spi_slave_regbank #(.DATA_W(32), .ADDR_W(4), .N_WR(16), .N_RD(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
      .SPI_MISO(SPI_MISO), .miso_data(miso_data), .mosi_data(mosi_data),
      .wr_strobe(wr_strobe), .frame_err_cnt(frame_err_cnt));

   spi_slave_regbank #(.DATA_W(32), .ADDR_W(4), .N_WR(8), .N_RD(16), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .reset(reset), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
      .SPI_MISO(SPI_MISO8), .miso_data(miso_data), .mosi_data(mosi_data8),
      .wr_strobe(wr_strobe8), .frame_err_cnt(frame_err_cnt8));

   always #5 clk = ~clk;

   // every clk with a nonzero strobe is logged, so pulse width and bits can be checked
   always @(negedge clk) begin
      if (wr_strobe != '0)  sq0.push_back(wr_strobe);
      if (wr_strobe8 != '0) sq8.push_back(wr_strobe8);
   end

   function automatic logic [15:0] or0_from(input int b);
      logic [15:0] r = '0;
      for (int i = b; i < sq0.size(); i++) r |= sq0[i];
      return r;
   endfunction

   function automatic logic [7:0] or8_from(input int b);
      logic [7:0] r = '0;
      for (int i = b; i < sq8.size(); i++) r |= sq8[i];
      return r;
   endfunction

   task automatic spi_bit(input logic m, output logic s);
      SPI_MOSI = m;
      #(HALF);
      s = SPI_MISO;
      SPI_CLK = 1'b1;
      #(HALF);
      SPI_CLK = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] v, input int n, output logic [31:0] rx);
      logic s;
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_bit(v[i], s);
         rx = {rx[30:0], s};
      end
   endtask

   task automatic cs_low();
      @(negedge clk);
      SPI_CS = 1'b0;
      #(HALF);
   endtask

   task automatic cs_high();
      #(HALF);
      SPI_CS = 1'b1;
      #(4*HALF);
   endtask

   task automatic test_reset();
      int b;
      reset = 1'b1;
      repeat (10) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (SPI_MISO !== 1'b0 || SPI_MISO8 !== 1'b0)
         $display("FAIL reset_miso: got %b/%b want 0/0", SPI_MISO, SPI_MISO8);
      else n_pass++;
      n_checks++;
      if (mosi_data !== '0) $display("FAIL reset_mosi: got %h want 0", mosi_data);
      else n_pass++;
      n_checks++;
      if (wr_strobe !== '0) $display("FAIL reset_strobe: got %h want 0", wr_strobe);
      else n_pass++;
      n_checks++;
      if (frame_err_cnt !== 8'd0) $display("FAIL reset_err: got %0d want 0", frame_err_cnt);
      else n_pass++;
      b = sq0.size();
      repeat (4) begin
         SPI_CLK = 1'b1;
         #(HALF);
         SPI_CLK = 1'b0;
         #(HALF);
      end
      n_checks++;
      if (sq0.size() != b) $display("FAIL idle_clk_strobe: got %0d pulses want 0", sq0.size() - b);
      else n_pass++;
      n_checks++;
      if (SPI_MISO !== 1'b0) $display("FAIL idle_clk_miso: got %b want 0", SPI_MISO);
      else n_pass++;
   endtask

   task automatic test_single_write();
      int b;
      logic [31:0] rx;
      b = sq0.size();
      cs_low();
      xfer(32'h83, 8, rx);
      xfer(32'hDEADBEEF, 32, rx);
      cs_high();
      exp0[3*32 +: 32] = 32'hDEADBEEF;
      exp8[3*32 +: 32] = 32'hDEADBEEF;
      n_checks++;
      if (mosi_data !== exp0) $display("FAIL write_data: got %h want %h", mosi_data, exp0);
      else n_pass++;
      n_checks++;
      if (sq0.size() - b != 1) $display("FAIL write_pulse_len: got %0d clks want 1", sq0.size() - b);
      else n_pass++;
      n_checks++;
      if (or0_from(b) !== 16'h0008) $display("FAIL write_strobe: got %h want 0008", or0_from(b));
      else n_pass++;
      n_checks++;
      if (frame_err_cnt !== 8'd0) $display("FAIL write_err: got %0d want 0", frame_err_cnt);
      else n_pass++;
   endtask

   task automatic test_burst_read();
      int b;
      logic [31:0] rx;
      logic [31:0] want [3];
      want[0] = 32'h11112222;
      want[1] = 32'h33334444;
      want[2] = 32'h55556666;
      miso_data[14*32 +: 32] = want[0];
      miso_data[15*32 +: 32] = want[1];
      miso_data[0*32 +: 32]  = want[2];
      miso_data[1*32 +: 32]  = 32'h0BADF00D;
      b = sq0.size();
      cs_low();
      miso_data[14*32 +: 32] = 32'hAAAA0000;
      miso_data[15*32 +: 32] = 32'hBBBB0000;
      miso_data[0*32 +: 32]  = 32'hCCCC0000;
      xfer(32'h0E, 8, rx);
      n_checks++;
      if (rx[7:0] !== 8'h00) $display("FAIL read_cmd_miso: got %h want 00", rx[7:0]);
      else n_pass++;
      for (int w = 0; w < 3; w++) begin
         xfer(32'h0, 32, rx);
         n_checks++;
         if (rx !== want[w]) $display("FAIL read_word%0d: got %h want %h", w, rx, want[w]);
         else n_pass++;
      end
      cs_high();
      n_checks++;
      if (mosi_data !== exp0) $display("FAIL read_mosi_untouched: got %h want %h", mosi_data, exp0);
      else n_pass++;
      n_checks++;
      if (sq0.size() != b) $display("FAIL read_strobe: got %0d pulses want 0", sq0.size() - b);
      else n_pass++;
   endtask

   task automatic test_boundary();
      int b0, b8;
      logic [31:0] rx;
      b0 = sq0.size();
      b8 = sq8.size();
      cs_low();
      xfer(32'h87, 8, rx);
      xfer(32'h0000000A, 32, rx);
      xfer(32'h0000000B, 32, rx);
      cs_high();
      exp0[7*32 +: 32] = 32'hA;
      exp0[8*32 +: 32] = 32'hB;
      exp8[7*32 +: 32] = 32'hA;
      n_checks++;
      if (mosi_data8 !== exp8) $display("FAIL bound_data: got %h want %h", mosi_data8, exp8);
      else n_pass++;
      n_checks++;
      if (sq8.size() - b8 != 1) $display("FAIL bound_pulses: got %0d want 1", sq8.size() - b8);
      else n_pass++;
      n_checks++;
      if (or8_from(b8) !== 8'h80) $display("FAIL bound_strobe: got %h want 80", or8_from(b8));
      else n_pass++;
      n_checks++;
      if (mosi_data !== exp0) $display("FAIL bound_full_data: got %h want %h", mosi_data, exp0);
      else n_pass++;
      n_checks++;
      if (or0_from(b0) !== 16'h0180) $display("FAIL bound_full_strobe: got %h want 0180", or0_from(b0));
      else n_pass++;
   endtask

   task automatic test_malformed();
      int b;
      logic [31:0] rx;
      b = sq0.size();
      cs_low();
      xfer(32'h81, 8, rx);
      xfer(32'hABCDE, 20, rx);
      cs_high();
      n_checks++;
      if (frame_err_cnt !== 8'd1) $display("FAIL err_first: got %0d want 1", frame_err_cnt);
      else n_pass++;
      n_checks++;
      if (mosi_data !== exp0 || sq0.size() != b)
         $display("FAIL err_no_write: got %h pulses %0d want %h pulses 0", mosi_data, sq0.size() - b, exp0);
      else n_pass++;
      repeat (253) begin
         cs_low();
         cs_high();
      end
      n_checks++;
      if (frame_err_cnt !== 8'd254) $display("FAIL err_254: got %0d want 254", frame_err_cnt);
      else n_pass++;
      repeat (46) begin
         cs_low();
         cs_high();
      end
      n_checks++;
      if (frame_err_cnt !== 8'd255 || frame_err_cnt8 !== 8'd255)
         $display("FAIL err_saturate: got %0d/%0d want 255/255", frame_err_cnt, frame_err_cnt8);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int b;
      logic [31:0] rx;
      cs_low();
      xfer(32'h82, 8, rx);
      xfer(32'hCAF, 12, rx);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp0 = '0;
      exp8 = '0;
      n_checks++;
      if (mosi_data !== '0 || frame_err_cnt !== 8'd0)
         $display("FAIL mid_reset_vals: got %h err %0d want 0 err 0", mosi_data, frame_err_cnt);
      else n_pass++;
      b = sq0.size();
      xfer(32'hEBABE, 20, rx);
      cs_high();
      n_checks++;
      if (sq0.size() != b || mosi_data !== '0)
         $display("FAIL mid_ignored: got %0d pulses data %h want 0 pulses data 0", sq0.size() - b, mosi_data);
      else n_pass++;
      n_checks++;
      if (frame_err_cnt !== 8'd0) $display("FAIL mid_err: got %0d want 0", frame_err_cnt);
      else n_pass++;
      b = sq0.size();
      cs_low();
      xfer(32'h82, 8, rx);
      xfer(32'h12345678, 32, rx);
      cs_high();
      exp0[2*32 +: 32] = 32'h12345678;
      exp8[2*32 +: 32] = 32'h12345678;
      n_checks++;
      if (mosi_data !== exp0) $display("FAIL mid_next_data: got %h want %h", mosi_data, exp0);
      else n_pass++;
      n_checks++;
      if (sq0.size() - b != 1 || or0_from(b) !== 16'h0004)
         $display("FAIL mid_next_strobe: got %0d pulses %h want 1 pulses 0004", sq0.size() - b, or0_from(b));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int b;
      logic [31:0] rx;
      b = sq0.size();
      cs_low();
      xfer(32'h8E, 8, rx);
      xfer(32'h1, 32, rx);
      xfer(32'h2, 32, rx);
      xfer(32'h3, 32, rx);
      cs_high();
      cs_low();
      xfer(32'h81, 8, rx);
      xfer(32'h77, 32, rx);
      cs_high();
      exp0[14*32 +: 32] = 32'h1;
      exp0[15*32 +: 32] = 32'h2;
      exp0[0*32 +: 32]  = 32'h3;
      exp0[1*32 +: 32]  = 32'h77;
      exp8[0*32 +: 32]  = 32'h3;
      exp8[1*32 +: 32]  = 32'h77;
      n_checks++;
      if (mosi_data !== exp0) $display("FAIL b2b_data: got %h want %h", mosi_data, exp0);
      else n_pass++;
      n_checks++;
      if (sq0.size() - b != 4 || or0_from(b) !== 16'hC003)
         $display("FAIL b2b_strobe: got %0d pulses %h want 4 pulses C003", sq0.size() - b, or0_from(b));
      else n_pass++;
      n_checks++;
      if (mosi_data8 !== exp8) $display("FAIL b2b_data8: got %h want %h", mosi_data8, exp8);
      else n_pass++;
      n_checks++;
      if (frame_err_cnt !== 8'd0) $display("FAIL b2b_err: got %0d want 0", frame_err_cnt);
      else n_pass++;
   endtask

   initial begin
      reset     = 1'b1;
      SPI_CLK   = 1'b0;
      SPI_CS    = 1'b1;
      SPI_MOSI  = 1'b0;
      miso_data = '0;
      exp0      = '0;
      exp8      = '0;
      test_reset();
      test_single_write();
      test_burst_read();
      test_boundary();
      test_malformed();
      test_reset_midframe();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
